sequenciador_polinomio: RTL and testbench
=========================================

Name: sequenciador_polinomio

Overview:
- Initiator and consumer for the polynomial evaluator's enable/ready/valid handshake.
- Latches one coefficient set (A, B, C) and sweeps N_PONTOS X values, starting at x_inicio and stepping by x_passo.
- Issues one evaluation per X, captures each y into an internal result buffer, and exposes the buffer through a read port.
- Sits between the test/top-level controller and the evaluator; it is the other end of the evaluator's interface.

Parameters:
- N_PONTOS, 8, number of X samples per sweep (power of two, 2..16).
- TIMEOUT, 64, maximum cycles spent in WAIT for ev_valid before aborting.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep when idle; ignored while busy.
- x_inicio  in  8  signed first X.
- x_passo  in  8  signed X increment.
- coef_a, coef_b, coef_c  in  16 each  signed coefficients, latched on start.
- ev_ready  in  1  evaluator idle / able to accept.
- ev_valid  in  1  evaluator result strobe, one cycle.
- ev_y  in  16  signed evaluator result.
- ev_x  out  8  X driven to the evaluator.
- ev_a, ev_b, ev_c  out  16 each  latched coefficients driven to the evaluator.
- ev_enable  out  1  evaluation request.
- rd_addr  in  clog2(N_PONTOS)  buffer read address.
- rd_data  out  16  buffer[rd_addr], combinational read.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at sweep end, normal or aborted.
- erro_timeout  out  1  sticky; cleared on the next accepted start.
- count  out  clog2(N_PONTOS)+1  number of results stored in the current/last sweep.

Behaviour:
- Reset (synchronous, dominant over every other input):
  - state=IDLE; all outputs 0.
  - ev_x/ev_a/ev_b/ev_c=0, count=0, erro_timeout=0.
  - All buffer entries = 0 and internal timer = 0.
  - A reset mid-sweep aborts the sweep with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, FIM.
- IDLE:
  - On start=1: latch coefficients into ev_a/ev_b/ev_c, ev_x<=x_inicio, idx<=0, count<=0, erro_timeout<=0, go to ISSUE.
- ISSUE:
  - ev_enable=1 (Moore output, decoded from state).
  - The handshake completes at the edge where ev_enable=1 and ev_ready=1; then timer<=0 and go to WAIT.
  - With ev_ready=0, stay in ISSUE indefinitely; no timeout applies here.
- WAIT:
  - ev_enable=0; timer increments each cycle.
  - On ev_valid=1:
    - buffer[idx]<=ev_y, count<=idx+1.
    - If idx==N_PONTOS-1, go to FIM.
    - Otherwise idx<=idx+1, ev_x<=ev_x+x_passo (8-bit two's-complement wrap, no saturation), go to ISSUE.
  - If ev_valid=0 and timer==TIMEOUT-1: erro_timeout<=1, go to FIM. The buffer keeps its partial results; count is unchanged.
  - ev_valid takes priority over timeout in the same cycle.
- FIM: done=1 for exactly one cycle, then go to IDLE.
- ev_valid outside WAIT is ignored and does not write the buffer.
- start outside IDLE is ignored. start in the cycle FIM is active is also ignored; it must be reasserted in IDLE.
- ev_x/ev_a/ev_b/ev_c stay stable from start until the next accepted start.
- Throughput: one result per (ISSUE wait + 1 + evaluator latency) cycles.
- Minimum latency start→done is N_PONTOS*(L+1)+2, where L is the cycles from enable acceptance to ev_valid.
- Buffer reads are legal at any time. rd_addr>=count returns the stale or zero contents.

Test Plan:
- Normal sweep:
  - Stimulus: A=1, B=2, C=3, x_inicio=0, x_passo=1; bench evaluator model with latency 3, ready always high.
  - Required response: buffer = 3, 6, 11, 18, 27, 38, 51, 66; count=8; one done pulse; erro_timeout=0; start→done = 8*4+2 = 34 cycles.
- Wrap-around:
  - Stimulus: x_inicio=126, x_passo=1, A=0, B=1, C=0.
  - Required response: ev_x sequence 126, 127, -128, -127, ..., -123; buffer holds the same values sign-extended to 16 bits.
- Backpressure:
  - Stimulus: hold ev_ready=0 for 10 cycles during the 3rd ISSUE.
  - Required response: ev_enable stays 1; ev_x is unchanged; no timeout; sweep completes with correct data.
- Timeout:
  - Stimulus: model drops ev_valid after 2 results.
  - Required response: after 64 WAIT cycles, erro_timeout=1, done pulses, count=2, buffer[0..1] valid; the next start clears erro_timeout.
- Reset and busy start:
  - Stimulus: assert start while busy; then assert reset at the 5th result.
  - Required response: the busy start has no effect. After reset: busy=0, count=0, all outputs 0, every rd_data read returns 0, no done pulse.
- Stray valid:
  - Stimulus: pulse ev_valid while in IDLE and while in ISSUE.
  - Required response: buffer and count unchanged.

Source files
------------

// File: rtl/sequenciador_polinomio_if.sv
// Evaluator handshake bundle: the sequencer (master) drives X and the coefficients
// and requests evaluations; the evaluator (slave) answers with ready/valid/y.
interface sequenciador_polinomio_if;
    logic [7:0]  ev_x;
    logic [15:0] ev_a;
    logic [15:0] ev_b;
    logic [15:0] ev_c;
    logic        ev_enable;
    logic        ev_ready;
    logic        ev_valid;
    logic [15:0] ev_y;

    modport master (
        output ev_x, ev_a, ev_b, ev_c, ev_enable,
        input  ev_ready, ev_valid, ev_y
    );

    modport slave (
        input  ev_x, ev_a, ev_b, ev_c, ev_enable,
        output ev_ready, ev_valid, ev_y
    );
endinterface

// File: rtl/sequenciador_polinomio.sv
// Sweeps N_PONTOS X values through the polynomial evaluator for one latched
// coefficient set and stores each result in a readable buffer.
module sequenciador_polinomio #(
    parameter int N_PONTOS = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [7:0]                  x_inicio_i,
    input  logic [7:0]                  x_passo_i,
    input  logic [15:0]                 coef_a_i,
    input  logic [15:0]                 coef_b_i,
    input  logic [15:0]                 coef_c_i,
    sequenciador_polinomio_if.master    ev,
    input  logic [$clog2(N_PONTOS)-1:0] rd_addr_i,
    output logic [15:0]                 rd_data_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        erro_timeout_o,
    output logic [$clog2(N_PONTOS):0]   count_o
);
    localparam int AW = $clog2(N_PONTOS);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIM} state_t;

    state_t        state_q;
    logic [7:0]    ev_x_q;
    logic [7:0]    ev_x_d;
    logic [15:0]   a_q;
    logic [15:0]   b_q;
    logic [15:0]   c_q;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          erro_q;
    logic [TW-1:0] timer_q;
    logic          buf_we;
    logic [15:0]   mem_w [N_PONTOS];

    // 8-bit add wraps naturally, which is the intended X behaviour
    assign ev_x_d  = ev_x_q + x_passo_i;
    assign idx_d   = idx_q + AW'(1);
    assign count_d = {1'b0, idx_q} + (AW + 1)'(1);
    assign buf_we  = (state_q == WAIT) && ev.ev_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ev_x_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            count_q <= '0;
            erro_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= coef_a_i;
                        b_q     <= coef_b_i;
                        c_q     <= coef_c_i;
                        ev_x_q  <= x_inicio_i;
                        idx_q   <= '0;
                        count_q <= '0;
                        erro_q  <= 1'b0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ev.ev_ready) begin
                        timer_q <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // a result arriving on the last timer cycle still counts
                    if (ev.ev_valid) begin
                        count_q <= count_d;
                        if (idx_q == AW'(N_PONTOS - 1)) begin
                            state_q <= FIM;
                        end else begin
                            idx_q   <= idx_d;
                            ev_x_q  <= ev_x_d;
                            state_q <= ISSUE;
                        end
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        erro_q  <= 1'b1;
                        state_q <= FIM;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                FIM: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register-based buffer: every entry must clear on reset
    for (genvar gi = 0; gi < N_PONTOS; gi++) begin : g_buf
        logic [15:0] entry_q;
        always_ff @(posedge clock) begin
            if (reset) begin
                entry_q <= '0;
            end else if (buf_we && (idx_q == AW'(gi))) begin
                entry_q <= ev.ev_y;
            end
        end
        assign mem_w[gi] = entry_q;
    end

    assign rd_data_o      = mem_w[rd_addr_i];
    assign ev.ev_x        = ev_x_q;
    assign ev.ev_a        = a_q;
    assign ev.ev_b        = b_q;
    assign ev.ev_c        = c_q;
    assign ev.ev_enable   = (state_q == ISSUE);
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == FIM);
    assign erro_timeout_o = erro_q;
    assign count_o        = count_q;
endmodule

// File: tb/tb_sequenciador_polinomio.sv
// Bench for sequenciador_polinomio: an evaluator model answers the handshake and
// an arithmetic reference predicts X sequence, buffer contents and latency.
module tb_sequenciador_polinomio;
    localparam int N  = 8;
    localparam int TO = 64;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    x_inicio = '0;
    logic [7:0]    x_passo = '0;
    logic [15:0]   ca = '0, cb = '0, cc = '0;
    logic [AW-1:0] rd_addr = '0;
    wire  [15:0]   rd_data;
    wire           busy, done, erro;
    wire  [AW:0]   count;

    sequenciador_polinomio_if evif ();

    sequenciador_polinomio #(.N_PONTOS(N), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start_i(start),
        .x_inicio_i(x_inicio), .x_passo_i(x_passo),
        .coef_a_i(ca), .coef_b_i(cb), .coef_c_i(cc),
        .ev(evif), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .busy_o(busy), .done_o(done), .erro_timeout_o(erro), .count_o(count)
    );

    always #5 clock = ~clock;

    int passed = 0, total = 0, failed = 0;
    int cyc = 0, done_cnt = 0;
    always @(posedge clock) cyc++;
    always @(negedge clock) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic
    logic [7:0]  cur_x0, cur_step;
    logic [15:0] exp_buf [N];

    function automatic logic [7:0] exp_x(input int k);
        int v;
        v = int'($signed(cur_x0)) + k * int'($signed(cur_step));
        return v[7:0];
    endfunction

    function automatic logic [15:0] poly(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [7:0] x);
        int xi, y;
        xi = int'($signed(x));
        y  = int'($signed(a)) * xi * xi + int'($signed(b)) * xi + int'($signed(c));
        return y[15:0];
    endfunction

    // Evaluator model configuration (set by the main sequence between sweeps)
    int lat = 3, drop_after = 0, block_issue = 0;
    int res_cnt = 0, hs_n = 0, issue_n = 0;
    bit drop_mode = 0, stray_issue = 0, stray_idle = 0;

    int          due = -1, edge_n = 0, blk = 0;
    bit          prev_en = 0;
    logic [15:0] y_pend = '0;

    initial begin
        evif.ev_valid = 1'b0;
        evif.ev_ready = 1'b1;
        evif.ev_y     = '0;
    end

    always @(posedge clock) begin
        bit hs;
        hs = evif.ev_enable && evif.ev_ready && !reset;
        edge_n++;
        if (hs) begin
            chk($sformatf("ev_x_issue%0d", hs_n), {24'd0, evif.ev_x}, {24'd0, exp_x(hs_n)});
            hs_n++;
            if (!(drop_mode && res_cnt >= drop_after)) begin
                due    = edge_n + lat;
                y_pend = poly(evif.ev_a, evif.ev_b, evif.ev_c, evif.ev_x);
            end
        end
        if (blk > 0) blk--;
        if (reset) due = -1;
        #1;
        evif.ev_valid = (due == edge_n + 1);
        if (evif.ev_valid) begin
            evif.ev_y = y_pend;
            res_cnt++;
            due = -1;
        end
        if (stray_idle) begin
            evif.ev_valid = 1'b1;
            evif.ev_y     = 16'hDEAD;
            stray_idle    = 0;
        end
        if (evif.ev_enable && !prev_en) begin
            issue_n++;
            if (issue_n == block_issue) blk = 10;
        end
        prev_en = evif.ev_enable;
        if (blk > 0) begin
            chk("bp_enable_held", {31'd0, evif.ev_enable}, 32'd1);
            chk("bp_x_stable", {24'd0, evif.ev_x}, {24'd0, exp_x(hs_n)});
            if (stray_issue && blk == 5) begin
                evif.ev_valid = 1'b1;
                evif.ev_y     = 16'hBEEF;
            end
            if (stray_issue && blk == 4)
                chk("stray_issue_count", {28'd0, count}, 32'd2);
        end
        evif.ev_ready = (blk == 0);
    end

    task automatic chk_buffer(input string tag);
        for (int k = 0; k < N; k++) begin
            rd_addr = AW'(k);
            #1;
            chk($sformatf("%s_buf%0d", tag, k), {16'd0, rd_data}, {16'd0, exp_buf[k]});
        end
    endtask

    task automatic do_sweep(input string tag, input logic [15:0] A, input logic [15:0] B,
                            input logic [15:0] C, input logic [7:0] x0, input logic [7:0] st,
                            input int L, input int blk_iss, input bit stray_iss, input int drop_n,
                            input bit busy_start, input bit fim_start, input int exp_lat);
        int c0, d, dn0, npts;
        bit got;
        @(negedge clock);
        cur_x0 = x0; cur_step = st;
        lat = L; block_issue = blk_iss; stray_issue = stray_iss;
        drop_mode = (drop_n != 0); drop_after = drop_n;
        res_cnt = 0; hs_n = 0; issue_n = 0;
        npts = (drop_n != 0) ? drop_n : N;
        for (int k = 0; k < npts; k++) exp_buf[k] = poly(A, B, C, exp_x(k));
        ca = A; cb = B; cc = C; x_inicio = x0; x_passo = st;
        dn0 = done_cnt;
        start = 1'b1; c0 = cyc;
        @(negedge clock);
        start = 1'b0;
        chk({tag, "_erro_clear"}, {31'd0, erro}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        got = 0; d = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (busy_start) begin
                start    = (i == 5);
                ca       = (i == 5) ? 16'h7777 : A;
                x_inicio = (i == 5) ? 8'h55 : x0;
            end
            if (done) begin
                got = 1; d = cyc;
            end else begin
                @(negedge clock);
            end
        end
        chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({tag, "_latency"}, d - c0 + 1, exp_lat);
        if (fim_start) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (fim_start) chk({tag, "_fim_start_ignored"}, {31'd0, busy}, 32'd0);
        @(negedge clock);
        chk({tag, "_done_pulses"}, done_cnt - dn0, 32'd1);
        chk({tag, "_count"}, {28'd0, count}, npts);
        chk({tag, "_erro"}, {31'd0, erro}, (drop_n != 0) ? 32'd1 : 32'd0);
        chk({tag, "_ev_a_stable"}, {16'd0, evif.ev_a}, {16'd0, A});
        chk_buffer(tag);
    endtask

    initial begin
        logic [4:0] cnt_before;
        int dn0, rl;
        logic [15:0] ra, rb, rc;
        logic [7:0]  rx, rs;
        bit hit5;

        for (int k = 0; k < N; k++) exp_buf[k] = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_enable", {31'd0, evif.ev_enable}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_ev_x", {24'd0, evif.ev_x}, 32'd0);
        reset = 1'b0;
        chk_buffer("rst");

        // Normal sweep with a busy start and a start during FIM
        do_sweep("normal", 16'd1, 16'd2, 16'd3, 8'd0, 8'd1, 3, 0, 0, 0, 1, 1, 34);
        begin
            logic [15:0] tbl [N];
            tbl = '{16'd3, 16'd6, 16'd11, 16'd18, 16'd27, 16'd38, 16'd51, 16'd66};
            for (int k = 0; k < N; k++) begin
                rd_addr = AW'(k);
                #1;
                chk($sformatf("normal_tbl%0d", k), {16'd0, rd_data}, {16'd0, tbl[k]});
            end
        end

        // Stray valid while idle
        @(negedge clock);
        cnt_before = count;
        stray_idle = 1;
        repeat (3) @(negedge clock);
        chk("stray_idle_count", {27'd0, count}, {27'd0, cnt_before});
        chk_buffer("stray_idle");

        // X wrap-around
        do_sweep("wrap", 16'd0, 16'd1, 16'd0, 8'd126, 8'd1, 3, 0, 0, 0, 0, 0, 34);
        rd_addr = 3'd2;
        #1;
        chk("wrap_buf2_literal", {16'd0, rd_data}, 32'h0000FF80);

        // Backpressure on the 3rd issue plus a stray valid during ISSUE
        do_sweep("bp", 16'hFFFE, 16'd5, 16'h0100, 8'hF0, 8'd3, 2, 3, 1, 0, 0, 0, N * 3 + 2 + 10);

        // Timeout after two results, then a clean sweep clears the error
        do_sweep("tmo", 16'd3, 16'hFFFF, 16'd7, 8'd10, 8'hFE, 3, 0, 0, 2, 0, 0, 2 * 4 + 1 + TO + 2);
        do_sweep("after_tmo", 16'd2, 16'd0, 16'd1, 8'd1, 8'd1, 1, 0, 0, 0, 0, 0, N * 2 + 2);

        // Randomized sweeps
        for (int r = 0; r < 3; r++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
            rx = 8'($urandom); rs = 8'($urandom);
            rl = int'($urandom_range(1, 5));
            do_sweep($sformatf("rand%0d", r), ra, rb, rc, rx, rs, rl, 0, 0, 0, 0, 0, N * (rl + 1) + 2);
        end

        // Reset at the 5th result
        @(negedge clock);
        cur_x0 = 8'd4; cur_step = 8'd1; lat = 3;
        block_issue = 0; stray_issue = 0; drop_mode = 0;
        res_cnt = 0; hs_n = 0; issue_n = 0;
        ca = 16'd1; cb = 16'd1; cc = 16'd1; x_inicio = 8'd4; x_passo = 8'd1;
        dn0 = done_cnt;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hit5 = 0;
        for (int i = 0; i < 200 && !hit5; i++) begin
            if (count == 4'd5) hit5 = 1;
            else @(negedge clock);
        end
        chk("mid_reached5", {31'd0, hit5}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_count", {28'd0, count}, 32'd0);
        chk("mid_erro", {31'd0, erro}, 32'd0);
        chk("mid_enable", {31'd0, evif.ev_enable}, 32'd0);
        chk("mid_ev_x", {24'd0, evif.ev_x}, 32'd0);
        chk("mid_ev_abc", {evif.ev_a, evif.ev_b | evif.ev_c}, 32'd0);
        for (int k = 0; k < N; k++) exp_buf[k] = '0;
        chk_buffer("mid");
        repeat (4) @(negedge clock);
        chk("mid_no_done", done_cnt - dn0, 32'd0);
        chk("mid_still_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
